// File: rtl/ysyx_040729_csr_pkg.sv
// Shared constants for the ysyx_040729 machine-mode CSR file: addresses, write ops, irq codes.
package ysyx_040729_csr_pkg;

    localparam logic [11:0] CsrMstatus  = 12'h300;
    localparam logic [11:0] CsrMisa     = 12'h301;
    localparam logic [11:0] CsrMie      = 12'h304;
    localparam logic [11:0] CsrMtvec    = 12'h305;
    localparam logic [11:0] CsrMscratch = 12'h340;
    localparam logic [11:0] CsrMepc     = 12'h341;
    localparam logic [11:0] CsrMcause   = 12'h342;
    localparam logic [11:0] CsrMtval    = 12'h343;
    localparam logic [11:0] CsrMip      = 12'h344;
    localparam logic [11:0] CsrMhartid  = 12'hF14;
    localparam logic [11:0] CsrMcycle   = 12'hB00;
    localparam logic [11:0] CsrMinstret = 12'hB02;
    localparam logic [11:0] CsrMcycleh  = 12'hB80;
    localparam logic [11:0] CsrMinstreth = 12'hB82;
    localparam logic [11:0] CsrCycle    = 12'hC00;
    localparam logic [11:0] CsrInstret  = 12'hC02;
    localparam logic [11:0] CsrCycleh   = 12'hC80;
    localparam logic [11:0] CsrInstreth = 12'hC82;

    typedef enum logic [1:0] {
        CsrOpNone  = 2'b00,
        CsrOpWrite = 2'b01,
        CsrOpSet   = 2'b10,
        CsrOpClear = 2'b11
    } csr_op_e;

    localparam logic [3:0] IrqCodeMsi = 4'd3;
    localparam logic [3:0] IrqCodeMti = 4'd7;
    localparam logic [3:0] IrqCodeMei = 4'd11;

    localparam int unsigned MstatusMieBit  = 3;
    localparam int unsigned MstatusMpieBit = 7;

    // Interrupt bit vectors are kept packed as {MEI, MTI, MSI}.
    function automatic logic [63:0] irq_to_csr(input logic [2:0] bits);
        logic [63:0] v;
        v     = '0;
        v[3]  = bits[0];
        v[7]  = bits[1];
        v[11] = bits[2];
        return v;
    endfunction

endpackage

// File: rtl/ysyx_040729_csr_counter.sv
// 64-bit event counter with XLEN-wide write port(s); a write wins over the increment.
module ysyx_040729_csr_counter #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned WIDTH = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             we_lo_i,
    input  logic             we_hi_i,
    input  logic [XLEN-1:0]  wdata_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (we_lo_i || we_hi_i) begin
            if (we_lo_i) count_d[XLEN-1:0] = wdata_i;
            if (we_hi_i) count_d[WIDTH-1:WIDTH-32] = wdata_i[31:0];
        end else if (inc_i) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/ysyx_040729_csr_file.sv
// Machine-mode CSR file: Zicsr access, trap/mret bookkeeping and interrupt arbitration.
// Define CSR_COUNTERS_EN to add mcycle/minstret and their user aliases.
module ysyx_040729_csr_file
    import ysyx_040729_csr_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 64,
    parameter int unsigned           HART_ID     = 0,
    parameter logic [DATA_WIDTH-1:0] MTVEC_RESET = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [11:0]           csr_addr,
    input  logic [2:0]            csr_wfunc,
    input  logic [4:0]            csr_uimm,
    input  logic [DATA_WIDTH-1:0] csr_wsrc,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  csr_illegal_o,
    input  logic                  trap_i,
    input  logic [DATA_WIDTH-1:0] trap_cause_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic [DATA_WIDTH-1:0] trap_tval_i,
    input  logic                  mret_i,
    input  logic                  retire_i,
    input  logic                  flow_i,
    input  logic                  eirp_i,
    input  logic                  tirp_i,
    input  logic                  sirp_i,
    output logic                  irq_o,
    output logic [DATA_WIDTH-1:0] irq_cause_o,
    output logic [DATA_WIDTH-1:0] trap_vec_o,
    output logic [DATA_WIDTH-1:0] mepc_o
);

    localparam logic [63:0] MisaFull = (DATA_WIDTH == 64) ? 64'h8000_0000_0000_1100
                                                          : 64'h0000_0000_4000_1100;
    // MPP hardwired to M; UXL/SXL fields vanish when truncated to RV32.
    localparam logic [63:0] MstatusFixed = 64'h0000_000A_0000_1800;

    logic                  mstatus_mie_q, mstatus_mie_d;
    logic                  mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]            mie_q, mie_d;
    logic [2:0]            mip_q, mip_d;
    logic [DATA_WIDTH-1:0] mtvec_q, mtvec_d;
    logic [DATA_WIDTH-1:0] mscratch_q, mscratch_d;
    logic [DATA_WIDTH-1:0] mepc_q, mepc_d;
    logic [DATA_WIDTH-1:0] mcause_q, mcause_d;
    logic [DATA_WIDTH-1:0] mtval_q, mtval_d;

    logic                  known, read_only, csr_we;
    logic [DATA_WIDTH-1:0] src, wdata;
    logic [2:0]            pend;
    csr_op_e               op;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle, minstret;

    ysyx_040729_csr_counter #(.XLEN(DATA_WIDTH), .WIDTH(64)) u_mcycle (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (1'b1),
        .we_lo_i (csr_we && csr_addr == CsrMcycle),
        .we_hi_i (csr_we && csr_addr == CsrMcycleh),
        .wdata_i (wdata),
        .count_o (mcycle)
    );

    ysyx_040729_csr_counter #(.XLEN(DATA_WIDTH), .WIDTH(64)) u_minstret (
        .clock   (clock),
        .reset   (reset),
        .inc_i   (retire_i && flow_i),
        .we_lo_i (csr_we && csr_addr == CsrMinstret),
        .we_hi_i (csr_we && csr_addr == CsrMinstreth),
        .wdata_i (wdata),
        .count_o (minstret)
    );
`else
    logic unused_retire;
    assign unused_retire = retire_i;
`endif

    always_comb begin
        csr_rdata = '0;
        known     = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            CsrMstatus: begin
                csr_rdata = DATA_WIDTH'(MstatusFixed);
                csr_rdata[MstatusMieBit]  = mstatus_mie_q;
                csr_rdata[MstatusMpieBit] = mstatus_mpie_q;
            end
            CsrMisa:     begin csr_rdata = DATA_WIDTH'(MisaFull); read_only = 1'b1; end
            CsrMie:      csr_rdata = DATA_WIDTH'(irq_to_csr(mie_q));
            CsrMtvec:    csr_rdata = mtvec_q;
            CsrMscratch: csr_rdata = mscratch_q;
            CsrMepc:     csr_rdata = mepc_q;
            CsrMcause:   csr_rdata = mcause_q;
            CsrMtval:    csr_rdata = mtval_q;
            CsrMip:      begin csr_rdata = DATA_WIDTH'(irq_to_csr(mip_q)); read_only = 1'b1; end
            CsrMhartid:  begin csr_rdata = DATA_WIDTH'(HART_ID); read_only = 1'b1; end
`ifdef CSR_COUNTERS_EN
            CsrMcycle, CsrCycle: begin
                csr_rdata = mcycle[DATA_WIDTH-1:0];
                read_only = (csr_addr == CsrCycle);
            end
            CsrMinstret, CsrInstret: begin
                csr_rdata = minstret[DATA_WIDTH-1:0];
                read_only = (csr_addr == CsrInstret);
            end
            CsrMcycleh, CsrCycleh: begin
                csr_rdata = DATA_WIDTH'(mcycle >> 32);
                read_only = (csr_addr == CsrCycleh);
                known     = (DATA_WIDTH == 32);
            end
            CsrMinstreth, CsrInstreth: begin
                csr_rdata = DATA_WIDTH'(minstret >> 32);
                read_only = (csr_addr == CsrInstreth);
                known     = (DATA_WIDTH == 32);
            end
`endif
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        op            = csr_op_e'(csr_wfunc[1:0]);
        csr_illegal_o = !known || (read_only && op != CsrOpNone);
        csr_we        = flow_i && op != CsrOpNone && !csr_illegal_o && !trap_i;
        src           = csr_wfunc[2] ? DATA_WIDTH'(csr_uimm) : csr_wsrc;
        case (op)
            CsrOpWrite: wdata = src;
            CsrOpSet:   wdata = csr_rdata | src;
            CsrOpClear: wdata = csr_rdata & ~src;
            default:    wdata = csr_rdata;
        endcase
    end

    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mip_d          = {eirp_i, tirp_i, sirp_i};
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (csr_we) begin
            case (csr_addr)
                CsrMstatus: begin
                    mstatus_mie_d  = wdata[MstatusMieBit];
                    mstatus_mpie_d = wdata[MstatusMpieBit];
                end
                CsrMie:      mie_d = {wdata[11], wdata[7], wdata[3]};
                // Reserved modes (>= 2) collapse to direct.
                CsrMtvec:    mtvec_d = {wdata[DATA_WIDTH-1:2], wdata[1] ? 2'b00 : wdata[1:0]};
                CsrMscratch: mscratch_d = wdata;
                CsrMepc:     mepc_d = {wdata[DATA_WIDTH-1:2], 2'b00};
                CsrMcause:   mcause_d = wdata;
                CsrMtval:    mtval_d = wdata;
                default: ;
            endcase
        end

        // Ordered so mret overrides a same-cycle mstatus write and trap overrides both.
        if (flow_i && mret_i && !trap_i) begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
        end

        if (flow_i && trap_i) begin
            mepc_d         = {trap_pc_i[DATA_WIDTH-1:2], 2'b00};
            mcause_d       = trap_cause_i;
            mtval_d        = trap_tval_i;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mip_q          <= mip_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    always_comb begin
        pend        = mip_q & mie_q;
        irq_o       = mstatus_mie_q && (pend != 3'b000);
        irq_cause_o = '0;
        if (irq_o) begin
            irq_cause_o[DATA_WIDTH-1] = 1'b1;
            irq_cause_o[3:0] = pend[2] ? IrqCodeMei : (pend[0] ? IrqCodeMsi : IrqCodeMti);
        end
        // Shifting by two drops the interrupt flag and scales the code to a word offset.
        if (mtvec_q[1:0] == 2'b01 && trap_cause_i[DATA_WIDTH-1]) begin
            trap_vec_o = {mtvec_q[DATA_WIDTH-1:2], 2'b00} + (trap_cause_i << 2);
        end else begin
            trap_vec_o = {mtvec_q[DATA_WIDTH-1:2], 2'b00};
        end
        mepc_o = mepc_q;
    end

endmodule

// File: tb/tb_ysyx_040729_csr_file.sv
// Scoreboard bench for ysyx_040729_csr_file: directed scenarios then random traffic vs a model.
module tb_ysyx_040729_csr_file;

    localparam int unsigned W          = 64;
    localparam int unsigned HART       = 5;
    localparam logic [63:0] MTVEC_INIT = 64'h0000_0000_8000_0100;
    localparam logic [63:0] IRQ_FLAG   = 64'h8000_0000_0000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic [11:0]   csr_addr;
    logic [2:0]    csr_wfunc;
    logic [4:0]    csr_uimm;
    logic [W-1:0]  csr_wsrc, csr_rdata;
    logic          csr_illegal_o;
    logic          trap_i, mret_i, retire_i, flow_i, eirp_i, tirp_i, sirp_i, irq_o;
    logic [W-1:0]  trap_cause_i, trap_pc_i, trap_tval_i, irq_cause_o, trap_vec_o, mepc_o;

    ysyx_040729_csr_file #(.DATA_WIDTH(W), .HART_ID(HART), .MTVEC_RESET(MTVEC_INIT)) dut (
        .clock(clock), .reset(reset), .csr_addr(csr_addr), .csr_wfunc(csr_wfunc),
        .csr_uimm(csr_uimm), .csr_wsrc(csr_wsrc), .csr_rdata(csr_rdata),
        .csr_illegal_o(csr_illegal_o), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
        .trap_pc_i(trap_pc_i), .trap_tval_i(trap_tval_i), .mret_i(mret_i),
        .retire_i(retire_i), .flow_i(flow_i), .eirp_i(eirp_i), .tirp_i(tirp_i),
        .sirp_i(sirp_i), .irq_o(irq_o), .irq_cause_o(irq_cause_o),
        .trap_vec_o(trap_vec_o), .mepc_o(mepc_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] a;
        logic [2:0]  wf;
        logic [4:0]  imm;
        logic [63:0] src;
        bit          tr;
        logic [63:0] cause, pc, tval;
        bit          mr, ret, fl, ei, ti, si;
    } stim_t;

    typedef struct {
        logic [63:0] rdata;
        logic        illegal;
        logic        irq;
        logic [63:0] cause;
        logic [63:0] vec;
        logic [63:0] mepc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    // Reference architectural state
    bit          m_mie, m_mpie, en_msi, en_mti, en_mei, p_msi, p_mti, p_mei;
    logic [63:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_cycle, m_instret;

    function automatic void model_reset();
        m_mie = 0; m_mpie = 0; en_msi = 0; en_mti = 0; en_mei = 0;
        p_msi = 0; p_mti = 0; p_mei = 0;
        m_mtvec = MTVEC_INIT; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
        m_cycle = 0; m_instret = 0;
    endfunction

    function automatic void model_read(input logic [11:0] a, output logic [63:0] v,
                                       output bit known, output bit ro);
        v = 0; known = 1; ro = 0;
        case (a)
            12'h300: v = 64'h0000_000A_0000_1800 | (m_mpie ? 64'h80 : 64'h0)
                         | (m_mie ? 64'h8 : 64'h0);
            12'h301: begin v = 64'h8000_0000_0000_1100; ro = 1; end
            12'h304: v = (en_mei ? 64'h800 : 64'h0) | (en_mti ? 64'h80 : 64'h0)
                         | (en_msi ? 64'h8 : 64'h0);
            12'h305: v = m_mtvec;
            12'h340: v = m_mscratch;
            12'h341: v = m_mepc;
            12'h342: v = m_mcause;
            12'h343: v = m_mtval;
            12'h344: begin
                v = (p_mei ? 64'h800 : 64'h0) | (p_mti ? 64'h80 : 64'h0)
                    | (p_msi ? 64'h8 : 64'h0);
                ro = 1;
            end
            12'hF14: begin v = 64'(HART); ro = 1; end
`ifdef CSR_COUNTERS_EN
            12'hB00: v = m_cycle;
            12'hB02: v = m_instret;
            12'hC00: begin v = m_cycle; ro = 1; end
            12'hC02: begin v = m_instret; ro = 1; end
`endif
            default: known = 0;
        endcase
    endfunction

    function automatic void model_step(input stim_t s, input logic [63:0] old, input bit ill);
        logic [63:0] sv, nv, cyc_n, ins_n;
        bit          wr, old_mpie;
        sv       = s.wf[2] ? {59'd0, s.imm} : s.src;
        case (s.wf[1:0])
            2'd1:    nv = sv;
            2'd2:    nv = old | sv;
            default: nv = old & ~sv;
        endcase
        wr       = s.fl && s.wf[1:0] != 2'd0 && !ill && !s.tr;
        old_mpie = m_mpie;
        cyc_n    = m_cycle + 1;
        ins_n    = m_instret + ((s.ret && s.fl) ? 64'd1 : 64'd0);
        if (wr) begin
            case (s.a)
                12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
                12'h304: begin en_msi = nv[3]; en_mti = nv[7]; en_mei = nv[11]; end
                12'h305: m_mtvec = (nv[1:0] >= 2'd2) ? (nv & ~64'h3) : nv;
                12'h340: m_mscratch = nv;
                12'h341: m_mepc = nv & ~64'h3;
                12'h342: m_mcause = nv;
                12'h343: m_mtval = nv;
                12'hB00: cyc_n = nv;
                12'hB02: ins_n = nv;
                default: ;
            endcase
        end
        if (s.fl && s.mr && !s.tr) begin m_mie = old_mpie; m_mpie = 1; end
        if (s.fl && s.tr) begin
            m_mepc = s.pc & ~64'h3; m_mcause = s.cause; m_mtval = s.tval;
            m_mpie = m_mie; m_mie = 0;
        end
        p_mei = s.ei; p_mti = s.ti; p_msi = s.si;
        m_cycle = cyc_n; m_instret = ins_n;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.a = 12'h340; s.wf = 3'd0; s.imm = 5'd0; s.src = 64'd0; s.tr = 0;
        s.cause = 64'd0; s.pc = 64'd0; s.tval = 64'd0;
        s.mr = 0; s.ret = 0; s.fl = 1; s.ei = 0; s.ti = 0; s.si = 0;
        return s;
    endfunction

    // Drive one cycle, queue its expected response, advance the model past the edge.
    task automatic apply(input stim_t s);
        exp_t        e;
        logic [63:0] v;
        bit          known, ro, ill;
        bit          pe, ps, pt;
        csr_addr = s.a; csr_wfunc = s.wf; csr_uimm = s.imm; csr_wsrc = s.src;
        trap_i = s.tr; trap_cause_i = s.cause; trap_pc_i = s.pc; trap_tval_i = s.tval;
        mret_i = s.mr; retire_i = s.ret; flow_i = s.fl;
        eirp_i = s.ei; tirp_i = s.ti; sirp_i = s.si;
        model_read(s.a, v, known, ro);
        ill = !known || (ro && s.wf[1:0] != 2'd0);
        pe = p_mei && en_mei; ps = p_msi && en_msi; pt = p_mti && en_mti;
        e.rdata   = v;
        e.illegal = ill;
        e.irq     = m_mie && (pe || ps || pt);
        e.cause   = !e.irq ? 64'd0 : IRQ_FLAG | (pe ? 64'd11 : (ps ? 64'd3 : 64'd7));
        e.vec     = m_mtvec & ~64'h3;
        if (m_mtvec[1:0] == 2'b01 && s.cause[63])
            e.vec = e.vec + 4 * (s.cause & ~IRQ_FLAG);
        e.mepc    = m_mepc;
        q.push_back(e);
        model_step(s, v, ill);
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("csr_rdata", csr_rdata, e.rdata);
                chk("csr_illegal_o", 64'(csr_illegal_o), 64'(e.illegal));
                chk("irq_o", 64'(irq_o), 64'(e.irq));
                chk("irq_cause_o", irq_cause_o, e.cause);
                chk("trap_vec_o", trap_vec_o, e.vec);
                chk("mepc_o", mepc_o, e.mepc);
                cyc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [11:0] pool [16] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                               12'h342, 12'h343, 12'h344, 12'hF14, 12'h7C0, 12'hB00,
                               12'hB02, 12'hC00, 12'hC02, 12'h305};

    initial begin
        stim_t s;
        reset = 1'b1;
        csr_addr = '0; csr_wfunc = '0; csr_uimm = '0; csr_wsrc = '0;
        trap_i = 0; trap_cause_i = '0; trap_pc_i = '0; trap_tval_i = '0;
        mret_i = 0; retire_i = 0; flow_i = 0; eirp_i = 0; tirp_i = 0; sirp_i = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset state, then mscratch write and set-immediate
        s = idle(); s.a = 12'h305; apply(s);
        s = idle(); s.wf = 3'b001; s.src = 64'hDEAD; apply(s);
        s = idle(); s.wf = 3'b110; s.imm = 5'd1; apply(s);
        s = idle(); apply(s);

        // Interrupt enable and priority
        s = idle(); s.a = 12'h300; s.wf = 3'b001; s.src = 64'h8; apply(s);
        s = idle(); s.a = 12'h304; s.wf = 3'b001; s.src = 64'h888; apply(s);
        s = idle(); s.ei = 1; s.ti = 1; apply(s);
        apply(s);
        s.ei = 0; apply(s);
        apply(s);
        s.si = 1; apply(s);
        apply(s);

        // Vectored mtvec, trap entry and mret
        s = idle(); s.a = 12'h305; s.wf = 3'b001; s.src = 64'h8000_0001; apply(s);
        s = idle(); s.tr = 1; s.cause = IRQ_FLAG | 64'd7; s.pc = 64'h1234; s.tval = 64'h55;
        apply(s);
        s = idle(); s.cause = 64'd2; s.a = 12'h300; apply(s);
        s = idle(); s.tr = 1; s.cause = 64'd2; s.pc = 64'h4000; apply(s);
        s = idle(); s.mr = 1; s.a = 12'h342; apply(s);
        s = idle(); s.a = 12'h300; apply(s);

        // Trap beats a same-cycle mepc write; mret beats a mstatus write
        s = idle(); s.a = 12'h341; s.wf = 3'b001; s.src = 64'h100; s.tr = 1;
        s.pc = 64'h2000; apply(s);
        s = idle(); s.a = 12'h341; apply(s);
        s = idle(); s.a = 12'h300; s.wf = 3'b011; s.src = 64'h88; s.mr = 1; apply(s);
        s = idle(); s.a = 12'h300; apply(s);

        // Read-only and unknown addresses; flow low blocks writes
        s = idle(); s.a = 12'hF14; s.wf = 3'b001; s.src = 64'h77; apply(s);
        s = idle(); s.a = 12'h7C0; s.wf = 3'b010; s.src = 64'h1; apply(s);
        s = idle(); s.a = 12'h340; s.wf = 3'b001; s.src = 64'h99; s.fl = 0; apply(s);
        s = idle(); apply(s);

`ifdef CSR_COUNTERS_EN
        s = idle(); s.a = 12'hB00; s.wf = 3'b001; s.src = '1; apply(s);
        s = idle(); s.a = 12'hB00; apply(s);
        apply(s);
        for (int i = 0; i < 5; i++) begin
            s = idle(); s.a = 12'hB02; s.ret = 1; s.fl = (i != 1 && i != 3); apply(s);
        end
        s = idle(); s.a = 12'hC02; apply(s);
`endif

        for (int i = 0; i < 3000; i++) begin
            s.a     = ($urandom_range(0, 9) == 0) ? 12'($urandom) : pool[$urandom_range(0, 15)];
            s.wf    = 3'($urandom_range(0, 7));
            s.imm   = 5'($urandom);
            s.src   = {$urandom, $urandom};
            s.tr    = ($urandom_range(0, 9) == 0);
            s.cause = {1'($urandom), 59'd0, 4'($urandom)};
            s.pc    = {$urandom, $urandom};
            s.tval  = {$urandom, $urandom};
            s.mr    = ($urandom_range(0, 7) == 0);
            s.ret   = 1'($urandom);
            s.fl    = ($urandom_range(0, 3) != 0);
            s.ei    = ($urandom_range(0, 3) == 0);
            s.ti    = ($urandom_range(0, 3) == 0);
            s.si    = ($urandom_range(0, 3) == 0);
            apply(s);
        end

        for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clock);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending responses, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
